// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Pipeline-side and data-bus signal bundle for mem_access_unit.
// Revision : 1.0
// ============================================================================
interface mem_access_unit_if;
    logic        ex_valid;
    logic [2:0]  mem_op;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        input  ex_valid, mem_op, alu_out, store_data, bus_rdata, bus_ack,
        output stall, load_data, load_valid, addr_err, bus_err,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output ex_valid, mem_op, alu_out, store_data, bus_rdata, bus_ack,
        input  stall, load_data, load_valid, addr_err, bus_err,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store unit over a single-outstanding req/ack bus.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_access_unit_if.master mau
);
    localparam logic [2:0] c_LW  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LHU = 3'b010;
    localparam logic [2:0] c_LB  = 3'b011;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_SW  = 3'b101;
    localparam logic [2:0] c_SH  = 3'b110;
    localparam logic [2:0] c_SB  = 3'b111;
    localparam logic [7:0] c_LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_op;
    logic [1:0]  r_lo;
    logic [7:0]  r_wait;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_load_valid;
    logic [31:0] r_load_data;
    logic        r_addr_err;
    logic        r_bus_err;

    logic        w_aligned;
    logic        w_is_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_accept;
    logic        w_misalign;
    logic        w_ack_ok;
    logic        w_timeout;

    function automatic logic [31:0] f_extend(input logic [2:0]  op,
                                             input logic [1:0]  lo,
                                             input logic [31:0] rd);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_res;
        v_byte = rd[{lo, 3'b000} +: 8];
        v_half = lo[1] ? rd[31:16] : rd[15:0];
        v_res  = rd;
        case (op)
            c_LB:    v_res = {{24{v_byte[7]}}, v_byte};
            c_LBU:   v_res = {24'h000000, v_byte};
            c_LH:    v_res = {{16{v_half[15]}}, v_half};
            c_LHU:   v_res = {16'h0000, v_half};
            default: v_res = rd;
        endcase
        return v_res;
    endfunction

    // Lane enables and replicated write data for the op currently on the inputs
    always_comb begin
        w_aligned  = 1'b1;
        w_be       = 4'b0000;
        w_wdata    = '0;
        w_is_store = (mau.mem_op == c_SW) || (mau.mem_op == c_SH) || (mau.mem_op == c_SB);
        case (mau.mem_op)
            c_LW, c_SW: begin
                w_aligned = (mau.alu_out[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = mau.store_data;
            end
            c_LH, c_LHU, c_SH: begin
                w_aligned = ~mau.alu_out[0];
                w_be      = mau.alu_out[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{mau.store_data[15:0]}};
            end
            default: begin
                w_be      = 4'b0001 << mau.alu_out[1:0];
                w_wdata   = {4{mau.store_data[7:0]}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_misalign   = 1'b0;
        w_ack_ok     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mau.ex_valid) begin
                    if (w_aligned) begin
                        w_accept     = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_misalign   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // ack wins over a timeout landing in the same cycle
                if (mau.bus_ack) begin
                    w_ack_ok     = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_wait == c_LAST_WAIT) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= 3'b000;
            r_lo         <= 2'b00;
            r_wait       <= 8'd0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= 4'b0000;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_addr_err   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_addr_err   <= w_misalign;
            r_bus_err    <= w_timeout;
            r_load_valid <= w_ack_ok & ~r_bus_we;
            r_load_data  <= (w_ack_ok & ~r_bus_we) ? f_extend(r_op, r_lo, mau.bus_rdata) : '0;
            if (w_accept) begin
                r_op        <= mau.mem_op;
                r_lo        <= mau.alu_out[1:0];
                r_wait      <= 8'd0;
                r_bus_req   <= 1'b1;
                r_bus_we    <= w_is_store;
                r_bus_be    <= w_be;
                r_bus_addr  <= {mau.alu_out[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
            end else if (r_state == S_REQ) begin
                r_wait <= r_wait + 8'd1;
                if (w_next_state != S_REQ) begin
                    r_bus_req <= 1'b0;
                    r_bus_we  <= 1'b0;
                    r_bus_be  <= 4'b0000;
                end
            end
        end
    end

    assign mau.stall      = ~rst & ((r_state == S_REQ) |
                                    ((r_state == S_IDLE) & mau.ex_valid & w_aligned));
    assign mau.load_data  = r_load_data;
    assign mau.load_valid = r_load_valid;
    assign mau.addr_err   = r_addr_err;
    assign mau.bus_err    = r_bus_err;
    assign mau.bus_req    = r_bus_req;
    assign mau.bus_we     = r_bus_we;
    assign mau.bus_addr   = r_bus_addr;
    assign mau.bus_be     = r_bus_be;
    assign mau.bus_wdata  = r_bus_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed bench for mem_access_unit with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;
    localparam int MAX_WAIT = 15;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if u_if();

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .mau (u_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic int op_size(input logic [2:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        return 1;
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    function automatic bit op_aligned(input logic [2:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % op_size(op)) == 0;
    endfunction

    function automatic logic [3:0] op_lanes(input logic [2:0] op, input logic [1:0] lo);
        return 4'(((1 << op_size(op)) - 1) << lo);
    endfunction

    function automatic logic [31:0] op_wdata(input logic [2:0] op, input logic [31:0] d);
        if (op_size(op) == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (op_size(op) == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] op_extend(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * lo);
        if (op_size(op) == 1) begin
            v = v & 32'h0000_00FF;
            if (op == LB && v[7]) v = v | 32'hFFFF_FF00;
        end else if (op_size(op) == 2) begin
            v = v & 32'h0000_FFFF;
            if (op == LH && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- reference model ----------------
    bit          m_busy, m_finishing, m_is_store;
    int          m_age;
    logic [2:0]  m_op;
    logic [1:0]  m_lo;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        e_lv, e_aerr, e_berr;
    logic [31:0] e_ld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_finishing = 0; m_is_store = 0; m_age = 0;
            m_op = 0; m_lo = 0; m_be = 0; m_addr = 0; m_wdata = 0;
            e_lv = 0; e_aerr = 0; e_berr = 0; e_ld = 0;
        end else begin
            e_lv = 0; e_aerr = 0; e_berr = 0; e_ld = 0;
            if (m_finishing) begin
                m_finishing = 0;
            end else if (m_busy) begin
                m_age++;
                if (u_if.bus_ack) begin
                    if (!m_is_store) begin
                        e_lv = 1;
                        e_ld = op_extend(m_op, m_lo, u_if.bus_rdata);
                    end
                    m_busy = 0; m_finishing = 1;
                end else if (m_age == MAX_WAIT) begin
                    e_berr = 1;
                    m_busy = 0; m_finishing = 1;
                end
            end else if (u_if.ex_valid) begin
                if (!op_aligned(u_if.mem_op, u_if.alu_out)) begin
                    e_aerr = 1;
                end else begin
                    m_busy     = 1;
                    m_age      = 0;
                    m_op       = u_if.mem_op;
                    m_lo       = u_if.alu_out[1:0];
                    m_is_store = op_store(u_if.mem_op);
                    m_be       = op_lanes(u_if.mem_op, u_if.alu_out[1:0]);
                    m_addr     = u_if.alu_out & 32'hFFFF_FFFC;
                    m_wdata    = op_wdata(u_if.mem_op, u_if.store_data);
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin : cmp
        logic exp_stall;
        exp_stall = !rst && (m_busy || (!m_finishing && u_if.ex_valid &&
                                        op_aligned(u_if.mem_op, u_if.alu_out)));
        check("stall",      u_if.stall,      exp_stall);
        check("bus_req",    u_if.bus_req,    m_busy);
        check("bus_we",     u_if.bus_we,     m_busy && m_is_store);
        check("bus_be",     u_if.bus_be,     m_busy ? m_be : 4'b0000);
        check("load_valid", u_if.load_valid, e_lv);
        check("addr_err",   u_if.addr_err,   e_aerr);
        check("bus_err",    u_if.bus_err,    e_berr);
        if (m_busy) begin
            check("bus_addr", u_if.bus_addr, m_addr);
            if (m_is_store) check("bus_wdata", u_if.bus_wdata, m_wdata);
        end
        if (e_lv || e_berr) check("load_data", u_if.load_data, e_ld);
    end

    // ---------------- bus monitor for literal checks ----------------
    int          req_cycles;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    always @(negedge clk) begin
        if (u_if.bus_req) begin
            req_cycles++;
            last_be    = u_if.bus_be;
            last_addr  = u_if.bus_addr;
            last_wdata = u_if.bus_wdata;
            last_we    = u_if.bus_we;
        end
    end

    // ---------------- bus responder ----------------
    int          resp_delay = 0;
    int          resp_cnt   = 0;
    bit          resp_en    = 1;
    bit          spur_ack   = 0;
    logic [31:0] resp_rdata = 0;
    always @(posedge clk) begin
        #1;
        if (u_if.bus_req) begin
            if (resp_en && resp_cnt == resp_delay) begin
                u_if.bus_ack   = 1'b1;
                u_if.bus_rdata = resp_rdata;
            end else begin
                u_if.bus_ack   = 1'b0;
                u_if.bus_rdata = 32'hDEAD_BEEF;
            end
            resp_cnt++;
        end else begin
            resp_cnt       = 0;
            u_if.bus_ack   = spur_ack;
            u_if.bus_rdata = spur_ack ? 32'hFFFF_FFFF : 32'h0;
        end
    end

    // Issue one op at posedge+1; returns after the completion cycle, at posedge+1.
    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int delay, input bit ack_en,
                         output int n_stall, output logic lv, output logic [31:0] ld,
                         output logic berr, output logic aerr);
        int guard;
        resp_delay = delay; resp_rdata = rdata; resp_en = ack_en; req_cycles = 0;
        u_if.mem_op = op; u_if.alu_out = addr; u_if.store_data = data; u_if.ex_valid = 1'b1;
        n_stall = 0; guard = 0;
        #1;
        while (u_if.stall && guard < 300) begin
            n_stall++; guard++;
            @(posedge clk); #2;
        end
        if (guard >= 300) begin
            n_checks++; n_errors++;
            $display("FAIL stall_bound: stall still %b after %0d cycles, required 0", u_if.stall, guard);
        end
        lv = u_if.load_valid; ld = u_if.load_data; berr = u_if.bus_err;
        @(posedge clk); #1;
        u_if.ex_valid = 1'b0;
        aerr = u_if.addr_err;
    endtask

    int          ns;
    logic        lv, berr, aerr;
    logic [31:0] ld;

    initial begin
        u_if.ex_valid = 0; u_if.mem_op = 0; u_if.alu_out = 0; u_if.store_data = 0;
        u_if.bus_ack = 0; u_if.bus_rdata = 0;
        req_cycles = 0; last_be = 0; last_addr = 0; last_wdata = 0; last_we = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_data", u_if.load_data, 32'h0);
        check("rst_bus_wdata", u_if.bus_wdata, 32'h0);
        check("rst_bus_addr",  u_if.bus_addr,  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LB, sign extension of lane 3
        do_op(LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1, ns, lv, ld, berr, aerr);
        check("lb_stall_cycles", ns, 2);
        check("lb_load_valid", lv, 1);
        check("lb_load_data", ld, 32'hFFFF_FF80);
        check("lb_bus_addr", last_addr, 32'h0000_1000);
        check("lb_bus_be", last_be, 4'b1000);

        // LBU, same lane zero-extended
        do_op(LBU, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 1, ns, lv, ld, berr, aerr);
        check("lbu_load_data", ld, 32'h0000_0080);

        // LHU / LH upper half with three wait cycles
        do_op(LHU, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3, 1, ns, lv, ld, berr, aerr);
        check("lhu_stall_cycles", ns, 5);
        check("lhu_load_data", ld, 32'h0000_BEEF);
        do_op(LH, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3, 1, ns, lv, ld, berr, aerr);
        check("lh_load_data", ld, 32'hFFFF_BEEF);

        // SB lane 1
        do_op(SB, 32'h0000_3001, 32'h0000_0055, 32'h0, 0, 1, ns, lv, ld, berr, aerr);
        check("sb_bus_we", last_we, 1);
        check("sb_bus_be", last_be, 4'b0010);
        check("sb_bus_wdata", last_wdata, 32'h5555_5555);
        check("sb_load_valid", lv, 0);

        // SH upper half
        do_op(SH, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 2, 1, ns, lv, ld, berr, aerr);
        check("sh_bus_be", last_be, 4'b1100);
        check("sh_bus_wdata", last_wdata, 32'hABCD_ABCD);

        // Misaligned SW
        do_op(SW, 32'h0000_3003, 32'hCAFE_F00D, 32'h0, 0, 1, ns, lv, ld, berr, aerr);
        check("sw_mis_addr_err", aerr, 1);
        check("sw_mis_req_cycles", req_cycles, 0);
        check("sw_mis_stall_cycles", ns, 0);

        // Misaligned LH
        do_op(LH, 32'h0000_2001, 32'h0, 32'h0, 0, 1, ns, lv, ld, berr, aerr);
        check("lh_mis_addr_err", aerr, 1);

        // LW timeout
        do_op(LW, 32'h0000_4000, 32'h0, 32'h0, 0, 0, ns, lv, ld, berr, aerr);
        check("to_req_cycles", req_cycles, MAX_WAIT);
        check("to_stall_cycles", ns, MAX_WAIT + 1);
        check("to_bus_err", berr, 1);
        check("to_load_valid", lv, 0);
        check("to_load_data", ld, 32'h0);

        // Ack exactly on the last allowed cycle wins
        do_op(LW, 32'h0000_4004, 32'h0, 32'h0BAD_F00D, MAX_WAIT - 1, 1, ns, lv, ld, berr, aerr);
        check("edge_bus_err", berr, 0);
        check("edge_load_data", ld, 32'h0BAD_F00D);

        // Reset in the middle of a request
        resp_en = 0;
        u_if.mem_op = LW; u_if.alu_out = 32'h0000_0040; u_if.ex_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_bus_req", u_if.bus_req, 1);
        #1 rst = 1'b1;
        u_if.ex_valid = 1'b0;
        #1;
        check("rst_bus_req_drop", u_if.bus_req, 0);
        check("rst_stall_drop", u_if.stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        spur_ack = 1;
        repeat (2) @(posedge clk);
        #1;
        spur_ack = 0;
        check("spur_load_valid", u_if.load_valid, 0);
        check("spur_bus_req", u_if.bus_req, 0);
        do_op(LW, 32'h0000_0044, 32'h0, 32'h1234_5678, 0, 1, ns, lv, ld, berr, aerr);
        check("post_rst_load_valid", lv, 1);
        check("post_rst_load_data", ld, 32'h1234_5678);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
